controle_multiciclo: RTL and testbench

- Multi-cycle successor to the single-cycle RV32I control decoder.
- Moore/Mealy FSM that sequences one instruction over several cycles through a shared memory, the IR, the ALUOut register and the register file.
- Supports R-type, lw, sw, beq, I-type ALU (addi family) and jal.
- Memory access completion comes from either a ready handshake or a fixed-latency counter; unknown opcodes trap to a sticky halt state.

---
 rtl/controle_multiciclo_if.sv | 34 +++
 rtl/controle_multiciclo.sv | 174 +++++++++++++++++
 tb/tb_controle_multiciclo.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_if.sv
// rtl/controle_multiciclo_if.sv - control bus between the multicycle controller and the datapath
interface controle_multiciclo_if;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       ir_write;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] mem_to_reg;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       pc_src;
   logic       illegal;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
             reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
             illegal, state_dbg
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
             reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
             illegal, state_dbg
   );
endinterface

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle RV32I control FSM with handshake or fixed-latency memory
module controle_multiciclo #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int MEM_LAT       = 1,
   parameter int EN_ITYPE      = 1,
   parameter int EN_JAL        = 1
) (
   input logic                   clk,
   input logic                   rst,
   controle_multiciclo_if.master bus
);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      EXEC_I    = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      JAL       = 4'd10,
      HALT      = 4'd15
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          illegal_q, illegal_d;
   logic          done;

   logic pc_write_r, pc_write_cond_r, ir_write_r, mem_read_r, mem_write_r, reg_write_r;
   logic iord_r, pc_src_r;
   logic [1:0] mem_to_reg_r, alu_src_a_r, alu_src_b_r, alu_op_r;

   assign done = (MEM_HANDSHAKE != 0) ? bus.mem_ready : (cnt_q == LAT_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = '0;
      pc_write_r      = 1'b0;
      pc_write_cond_r = 1'b0;
      ir_write_r      = 1'b0;
      mem_read_r      = 1'b0;
      mem_write_r     = 1'b0;
      reg_write_r     = 1'b0;
      iord_r          = 1'b0;
      pc_src_r        = 1'b0;
      mem_to_reg_r    = 2'd0;
      alu_src_a_r     = 2'd0;
      alu_src_b_r     = 2'd0;
      alu_op_r        = 2'd0;

      // Access states keep counting until done; the count is dropped on exit.
      if ((state_q == FETCH || state_q == MEM_READ || state_q == MEM_WRITE) &&
          MEM_HANDSHAKE == 0 && !done)
         cnt_d = cnt_q + 1'b1;

      case (state_q)
         FETCH: begin
            mem_read_r  = 1'b1;
            alu_src_b_r = 2'd2;
            if (done) begin
               ir_write_r = 1'b1;
               pc_write_r = 1'b1;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            alu_src_a_r = 2'd1;
            alu_src_b_r = 2'd1;
            case (bus.opcode)
               OP_LOAD, OP_STORE: state_d = MEM_ADDR;
               OP_RTYPE:          state_d = EXEC_R;
               OP_ITYPE:          state_d = (EN_ITYPE != 0) ? EXEC_I : HALT;
               OP_BRANCH:         state_d = BRANCH;
               OP_JAL:            state_d = (EN_JAL != 0) ? JAL : HALT;
               default:           state_d = HALT;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a_r = 2'd2;
            alu_src_b_r = 2'd1;
            state_d     = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            mem_read_r = 1'b1;
            iord_r     = 1'b1;
            if (done) state_d = MEM_WB;
         end
         MEM_WB: begin
            reg_write_r  = 1'b1;
            mem_to_reg_r = 2'd1;
            state_d      = FETCH;
         end
         MEM_WRITE: begin
            mem_write_r = 1'b1;
            iord_r      = 1'b1;
            if (done) state_d = FETCH;
         end
         EXEC_R: begin
            alu_src_a_r = 2'd2;
            alu_op_r    = 2'b10;
            state_d     = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a_r = 2'd2;
            alu_src_b_r = 2'd1;
            alu_op_r    = 2'b10;
            state_d     = ALU_WB;
         end
         ALU_WB: begin
            reg_write_r = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            alu_src_a_r     = 2'd2;
            alu_op_r        = 2'b01;
            pc_write_cond_r = 1'b1;
            pc_src_r        = 1'b1;
            state_d         = FETCH;
         end
         JAL: begin
            pc_write_r   = 1'b1;
            pc_src_r     = 1'b1;
            reg_write_r  = 1'b1;
            mem_to_reg_r = 2'd2;
            state_d      = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = HALT;
      endcase

      illegal_d = illegal_q | (state_d == HALT);
   end

   // Strobes are masked combinationally so nothing fires while rst is held.
   assign bus.pc_write      = pc_write_r & ~rst;
   assign bus.pc_write_cond = pc_write_cond_r & ~rst;
   assign bus.ir_write      = ir_write_r & ~rst;
   assign bus.mem_read      = mem_read_r & ~rst;
   assign bus.mem_write     = mem_write_r & ~rst;
   assign bus.reg_write     = reg_write_r & ~rst;
   assign bus.iord          = iord_r;
   assign bus.pc_src        = pc_src_r;
   assign bus.mem_to_reg    = mem_to_reg_r;
   assign bus.alu_src_a     = alu_src_a_r;
   assign bus.alu_src_b     = alu_src_b_r;
   assign bus.alu_op        = alu_op_r;
   assign bus.illegal       = illegal_q;
   assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - directed self-checking bench for controle_multiciclo
module tb_controle_multiciclo;
   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   controle_multiciclo_if ifa ();
   controle_multiciclo_if ifb ();
   controle_multiciclo_if ifc ();

   controle_multiciclo #(.MEM_HANDSHAKE(1), .MEM_LAT(1), .EN_ITYPE(1), .EN_JAL(1))
      dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
   controle_multiciclo #(.MEM_HANDSHAKE(0), .MEM_LAT(3), .EN_ITYPE(1), .EN_JAL(1))
      dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
   controle_multiciclo #(.MEM_HANDSHAKE(1), .MEM_LAT(1), .EN_ITYPE(1), .EN_JAL(0))
      dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

   task automatic pulse_rst(input int which);
      if (which == 0) rst_a = 1'b1;
      else if (which == 1) rst_b = 1'b1;
      else rst_c = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
   endtask

   task automatic test_reset;
      logic [5:0] s;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      ifa.mem_ready = 1'b1; ifb.mem_ready = 1'b1; ifc.mem_ready = 1'b1;
      ifa.opcode = 7'b0110011; ifb.opcode = 7'b0110011; ifc.opcode = 7'b0110011;
      ifa.zero = 1'b0; ifb.zero = 1'b0; ifc.zero = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      s = {ifa.pc_write, ifa.pc_write_cond, ifa.ir_write, ifa.mem_read, ifa.mem_write, ifa.reg_write};
      total++;
      if (s !== 6'b0) begin $display("FAIL reset_strobes_a got=%b exp=000000", s); bad++; end
      s = {ifb.pc_write, ifb.pc_write_cond, ifb.ir_write, ifb.mem_read, ifb.mem_write, ifb.reg_write};
      total++;
      if (s !== 6'b0) begin $display("FAIL reset_strobes_b got=%b exp=000000", s); bad++; end
      total++;
      if (ifa.state_dbg !== 4'd0) begin $display("FAIL reset_state got=%0d exp=0", ifa.state_dbg); bad++; end
      total++;
      if (ifc.illegal !== 1'b0) begin $display("FAIL reset_illegal got=%b exp=0", ifc.illegal); bad++; end
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
   endtask

   task automatic test_rtype;
      int st[4] = '{0, 1, 6, 8};
      pulse_rst(0);
      ifa.opcode = 7'b0110011; ifa.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (ifa.state_dbg !== 4'(st[i])) begin
            $display("FAIL rtype_state c%0d got=%0d exp=%0d", i, ifa.state_dbg, st[i]); bad++;
         end
         total++;
         if (ifa.reg_write !== (i == 3)) begin
            $display("FAIL rtype_reg_write c%0d got=%b exp=%b", i, ifa.reg_write, (i == 3)); bad++;
         end
         if (i == 2) begin
            total++;
            if ({ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op} !== 6'b10_00_10) begin
               $display("FAIL rtype_exec_sel got=%b exp=100010", {ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op}); bad++;
            end
         end
         if (i == 3) begin
            total++;
            if (ifa.mem_to_reg !== 2'd0) begin $display("FAIL rtype_mem_to_reg got=%0d exp=0", ifa.mem_to_reg); bad++; end
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (ifa.state_dbg !== 4'd0) begin $display("FAIL rtype_return got=%0d exp=0", ifa.state_dbg); bad++; end
      @(negedge clk);
   endtask

   task automatic test_lw_wait;
      int   st[9]  = '{0, 0, 0, 1, 2, 3, 3, 3, 4};
      logic rdy[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int   irw = 0;
      pulse_rst(0);
      ifa.opcode = 7'b0000011;
      for (int i = 0; i < 9; i++) begin
         ifa.mem_ready = rdy[i];
         #1;
         total++;
         if (ifa.state_dbg !== 4'(st[i])) begin
            $display("FAIL lw_state c%0d got=%0d exp=%0d", i, ifa.state_dbg, st[i]); bad++;
         end
         total++;
         if (ifa.mem_read !== (st[i] == 0 || st[i] == 3)) begin
            $display("FAIL lw_mem_read c%0d got=%b exp=%b", i, ifa.mem_read, (st[i] == 0 || st[i] == 3)); bad++;
         end
         if (ifa.ir_write === 1'b1) irw++;
         if (i == 2) begin
            total++;
            if (ifa.ir_write !== 1'b1) begin $display("FAIL lw_ir_write_done got=%b exp=1", ifa.ir_write); bad++; end
         end
         if (i == 7) begin
            total++;
            if (ifa.iord !== 1'b1) begin $display("FAIL lw_iord got=%b exp=1", ifa.iord); bad++; end
         end
         if (i == 8) begin
            total++;
            if ({ifa.reg_write, ifa.mem_to_reg} !== 3'b101) begin
               $display("FAIL lw_wb got=%b exp=101", {ifa.reg_write, ifa.mem_to_reg}); bad++;
            end
         end
         @(negedge clk);
      end
      total++;
      if (irw != 1) begin $display("FAIL lw_ir_write_pulses got=%0d exp=1", irw); bad++; end
      #1;
      total++;
      if (ifa.state_dbg !== 4'd0) begin $display("FAIL lw_return got=%0d exp=0", ifa.state_dbg); bad++; end
      @(negedge clk);
   endtask

   task automatic test_sw_fixed;
      int st[8] = '{0, 0, 0, 1, 2, 5, 5, 5};
      pulse_rst(1);
      ifb.opcode = 7'b0100011; ifb.mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         total++;
         if (ifb.state_dbg !== 4'(st[i])) begin
            $display("FAIL sw_state c%0d got=%0d exp=%0d", i, ifb.state_dbg, st[i]); bad++;
         end
         total++;
         if (ifb.ir_write !== (i == 2)) begin
            $display("FAIL sw_ir_write c%0d got=%b exp=%b", i, ifb.ir_write, (i == 2)); bad++;
         end
         total++;
         if ({ifb.mem_write, ifb.iord} !== {2{st[i] == 5}}) begin
            $display("FAIL sw_write_iord c%0d got=%b exp=%b", i, {ifb.mem_write, ifb.iord}, {2{st[i] == 5}}); bad++;
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (ifb.state_dbg !== 4'd0) begin $display("FAIL sw_return got=%0d exp=0", ifb.state_dbg); bad++; end
      @(negedge clk);
   endtask

   task automatic test_branch;
      for (int z = 1; z >= 0; z--) begin
         pulse_rst(0);
         ifa.opcode = 7'b1100011; ifa.mem_ready = 1'b1; ifa.zero = z[0];
         @(negedge clk); @(negedge clk);
         #1;
         total++;
         if (ifa.state_dbg !== 4'd9) begin $display("FAIL br_state z%0d got=%0d exp=9", z, ifa.state_dbg); bad++; end
         total++;
         if ({ifa.pc_write_cond, ifa.pc_src, ifa.alu_op, ifa.pc_write} !== 5'b11_01_0) begin
            $display("FAIL br_ctrl z%0d got=%b exp=11010", z, {ifa.pc_write_cond, ifa.pc_src, ifa.alu_op, ifa.pc_write}); bad++;
         end
         total++;
         if ({ifa.alu_src_a, ifa.alu_src_b} !== 4'b10_00) begin
            $display("FAIL br_sel z%0d got=%b exp=1000", z, {ifa.alu_src_a, ifa.alu_src_b}); bad++;
         end
         @(negedge clk);
         #1;
         total++;
         if (ifa.state_dbg !== 4'd0) begin $display("FAIL br_return z%0d got=%0d exp=0", z, ifa.state_dbg); bad++; end
         @(negedge clk);
      end
      ifa.zero = 1'b0;
   endtask

   task automatic test_jal_itype;
      pulse_rst(0);
      ifa.opcode = 7'b1101111; ifa.mem_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      total++;
      if (ifa.state_dbg !== 4'd10) begin $display("FAIL jal_state got=%0d exp=10", ifa.state_dbg); bad++; end
      total++;
      if ({ifa.pc_write, ifa.pc_src, ifa.reg_write, ifa.mem_to_reg} !== 5'b111_10) begin
         $display("FAIL jal_ctrl got=%b exp=11110", {ifa.pc_write, ifa.pc_src, ifa.reg_write, ifa.mem_to_reg}); bad++;
      end
      @(negedge clk);
      ifa.opcode = 7'b0010011;
      @(negedge clk); @(negedge clk);
      #1;
      total++;
      if ({ifa.state_dbg, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op} !== {4'd7, 6'b10_01_10}) begin
         $display("FAIL itype_exec got=%b exp=0111100110", {ifa.state_dbg, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op}); bad++;
      end
      @(negedge clk);
      #1;
      total++;
      if ({ifa.state_dbg, ifa.reg_write} !== {4'd8, 1'b1}) begin
         $display("FAIL itype_wb got=%b exp=10001", {ifa.state_dbg, ifa.reg_write}); bad++;
      end
      @(negedge clk);
   endtask

   task automatic test_illegal_halt;
      logic [5:0] s;
      pulse_rst(2);
      ifc.opcode = 7'b1101111; ifc.mem_ready = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (ifc.state_dbg !== 4'd1) begin $display("FAIL halt_decode got=%0d exp=1", ifc.state_dbg); bad++; end
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         ifc.mem_ready = i[0];
         ifc.opcode = i[1] ? 7'b0110011 : 7'b0000011;
         #1;
         s = {ifc.pc_write, ifc.pc_write_cond, ifc.ir_write, ifc.mem_read, ifc.mem_write, ifc.reg_write};
         total++;
         if ({ifc.state_dbg, ifc.illegal, s} !== {4'd15, 1'b1, 6'b0}) begin
            $display("FAIL halt_hold c%0d got=%b exp=11111000000", i, {ifc.state_dbg, ifc.illegal, s}); bad++;
         end
         @(negedge clk);
      end
      #1;
      rst_c = 1'b1;
      #1;
      total++;
      if ({ifc.state_dbg, ifc.illegal} !== 5'b0) begin
         $display("FAIL halt_rst_clear got=%b exp=00000", {ifc.state_dbg, ifc.illegal}); bad++;
      end
      @(negedge clk);
      rst_c = 1'b0;
      #1;
      total++;
      if ({ifc.state_dbg, ifc.mem_read} !== 5'b0000_1) begin
         $display("FAIL halt_to_fetch got=%b exp=00001", {ifc.state_dbg, ifc.mem_read}); bad++;
      end
      @(negedge clk);
   endtask

   task automatic test_async_rst;
      int st[4] = '{0, 0, 0, 1};
      pulse_rst(1);
      ifb.opcode = 7'b0100011; ifb.mem_ready = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      total++;
      if ({ifb.state_dbg, ifb.mem_write} !== {4'd5, 1'b1}) begin
         $display("FAIL arst_pre got=%b exp=01011", {ifb.state_dbg, ifb.mem_write}); bad++;
      end
      #1;
      rst_b = 1'b1;
      #1;
      total++;
      if ({ifb.state_dbg, ifb.mem_write} !== 5'b0) begin
         $display("FAIL arst_drop got=%b exp=00000", {ifb.state_dbg, ifb.mem_write}); bad++;
      end
      @(negedge clk);
      rst_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({ifb.state_dbg, ifb.ir_write} !== {4'(st[i]), (i == 2)}) begin
            $display("FAIL arst_refetch c%0d got=%b exp=%b", i, {ifb.state_dbg, ifb.ir_write}, {4'(st[i]), (i == 2)}); bad++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_sw_fixed();
      test_branch();
      test_jal_itype();
      test_illegal_halt();
      test_async_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
